// File: rtl/mvm_sched_pkg.sv
// Shared definitions for the matrix-vector multiply scheduler:
// FSM state encoding and command opcodes.
package mvm_sched_pkg;

    localparam logic [1:0] OP_LOAD_A = 2'd0;
    localparam logic [1:0] OP_LOAD_X = 2'd1;
    localparam logic [1:0] OP_RUN    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_X  = 3'd2,
        ST_MAC     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_WRITE_Y = 3'd5,
        ST_WAIT_Y  = 3'd6,
        ST_OUT     = 3'd7
    } state_t;

endpackage

// File: rtl/mvm_sched.sv
// Control scheduler for a K-lane matrix-vector multiplier: sequences matrix and
// vector loads, the MAC sweep with pipeline drain, result write-back and readout.
module mvm_sched
    import mvm_sched_pkg::*;
#(
    parameter int K       = 8,
    parameter int LOG_K   = 3,
    parameter int MAC_LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [K-1:0]     wr_en_a,
    output logic [LOG_K-1:0] addr_a,
    output logic [LOG_K-1:0] addr_x,
    output logic             wr_en_x,
    output logic             clear_acc,
    output logic             wr_en_y,
    output logic [LOG_K-1:0] sel_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             done,
    output logic             err,
    output logic [2:0]       dbg_state
);

    localparam int CW = 2 * LOG_K;
    localparam logic [CW-1:0] C_KK_LAST    = CW'(K * K - 1);
    localparam logic [CW-1:0] C_K_LAST     = CW'(K - 1);
    localparam logic [CW-1:0] C_DRAIN_LAST = CW'(K + MAC_LAT - 2);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_a_loaded;
    logic          r_x_loaded;
    logic          r_done;
    logic          r_err;

    // Handshakes: a beat transfers on a rising edge where valid and ready are both high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_a_loaded <= 1'b0;
            r_x_loaded <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cnt <= '0;
                        case (cmd_op)
                            OP_LOAD_A: begin
                                r_state    <= ST_LOAD_A;
                                r_a_loaded <= 1'b0;
                            end
                            OP_LOAD_X: begin
                                r_state    <= ST_LOAD_X;
                                r_x_loaded <= 1'b0;
                            end
                            OP_RUN: begin
                                if (r_a_loaded && r_x_loaded) r_state <= ST_MAC;
                                else                          r_err   <= 1'b1;
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                ST_LOAD_A: begin
                    if (din_valid) begin
                        if (r_cnt == C_KK_LAST) begin
                            r_state    <= ST_IDLE;
                            r_a_loaded <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD_X: begin
                    if (din_valid) begin
                        if (r_cnt == C_K_LAST) begin
                            r_state    <= ST_IDLE;
                            r_x_loaded <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                // The counter keeps running through DRAIN so WRITE_Y lands at K+MAC_LAT-1.
                ST_MAC: begin
                    if (r_cnt == C_K_LAST) r_state <= (MAC_LAT > 1) ? ST_DRAIN : ST_WRITE_Y;
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_DRAIN: begin
                    if (r_cnt == C_DRAIN_LAST) r_state <= ST_WRITE_Y;
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_WRITE_Y: r_state <= ST_WAIT_Y;
                ST_WAIT_Y: begin
                    r_state <= ST_OUT;
                    r_cnt   <= '0;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (r_cnt == C_K_LAST) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        din_ready = 1'b0;
        wr_en_a   = '0;
        addr_a    = '0;
        addr_x    = '0;
        wr_en_x   = 1'b0;
        clear_acc = 1'b0;
        wr_en_y   = 1'b0;
        sel_y     = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (r_state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_LOAD_A: begin
                din_ready = 1'b1;
                addr_a    = r_cnt[LOG_K-1:0];
                if (din_valid) wr_en_a[r_cnt[CW-1:LOG_K]] = 1'b1;
            end
            ST_LOAD_X: begin
                din_ready = 1'b1;
                addr_x    = r_cnt[LOG_K-1:0];
                wr_en_x   = din_valid;
            end
            ST_MAC: begin
                addr_a    = r_cnt[LOG_K-1:0];
                addr_x    = r_cnt[LOG_K-1:0];
                clear_acc = (r_cnt == '0);
            end
            // Holding the last address keeps the in-flight pipeline inputs stable.
            ST_DRAIN: begin
                addr_a = LOG_K'(K - 1);
                addr_x = LOG_K'(K - 1);
            end
            ST_WRITE_Y: wr_en_y = 1'b1;
            ST_OUT: begin
                out_valid = 1'b1;
                sel_y     = r_cnt[LOG_K-1:0];
                out_last  = (r_cnt == C_K_LAST);
            end
            default: ;
        endcase
    end

    assign done      = r_done;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: doc/mvm_sched.md
MVM_SCHED -- requirements
Module: mvm_sched
Interface
REQ-001 Parameter K, 8, matrix dimension, lane count and vector length; one datapath lane per matrix row.
REQ-002 Parameter LOG_K, 3, log2(K); width of every address and select output.
REQ-003 Parameter MAC_LAT, 3, cycles from address issue to product in accumulator (memory read, multiply register, add register).
REQ-004 One clock; reset is synchronous and active-high; ports named clk and reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_op  in  2  0=LOAD_A, 1=LOAD_X, 2=RUN, 3=reserved.
REQ-009 cmd_ready  out  1  high only in IDLE.
REQ-010 din_valid / din_ready  in / out  1 each  data_in beat handshake; data_in goes directly to the datapaths.
REQ-011 wr_en_a  out  K  one-hot matrix-memory write enable, bit r = lane r.
REQ-012 addr_a, addr_x  out  LOG_K each  matrix and vector memory addresses; all lanes share addr_a.
REQ-013 wr_en_x, clear_acc, wr_en_y  out  1 each  vector write, accumulator clear, result write.
REQ-014 sel_y  out  LOG_K  output lane select.
REQ-015 out_valid / out_ready / out_last  out / in / out  1 each  result beat handshake; out_last marks lane K-1.
REQ-016 done, err  out  1 each  single-cycle pulses.
Function
REQ-017 States SHALL be IDLE, LOAD_A, LOAD_X, MAC, DRAIN, WRITE_Y, WAIT_Y, OUT.
REQ-018 IDLE: a cmd_valid&cmd_ready beat SHALL select the next state by cmd_op (LOAD_A, LOAD_X, RUN->MAC) and zero the beat counter; op 3 pulses err and stays IDLE.
REQ-019 RUN with a_loaded=0 or x_loaded=0 SHALL pulse err the cycle after acceptance and stay IDLE.
REQ-020 LOAD_A: din_ready=1; beat n (0..K*K-1) SHALL drive wr_en_a bit n/K and addr_a=n%K combinationally in the accepting cycle; after beat K*K-1, go to IDLE and set a_loaded.
REQ-021 LOAD_X: din_ready=1; beat n (0..K-1) SHALL drive wr_en_x=1 and addr_x=n in the same cycle; after beat K-1, go to IDLE and set x_loaded.
REQ-022 Entering LOAD_A or LOAD_X SHALL clear the matching loaded flag; both flags persist across RUN so the matrix can be reused.
REQ-023 din_valid low SHALL stall the counter; all write enables are 0 when no beat is accepted.
REQ-024 MAC: K cycles; cycle c drives addr_a=addr_x=c; clear_acc=1 in cycle 0 only.
REQ-025 DRAIN: MAC_LAT-1 cycles with addresses held at K-1 and no enables asserted.
REQ-026 WRITE_Y: 1 cycle with wr_en_y=1, i.e. cycle K+MAC_LAT-1 counted from MAC cycle 0.
REQ-027 WAIT_Y: 1 cycle, covering the result-memory read latency.
REQ-028 OUT: out_valid=1 and sel_y=m; beat m advances on out_ready; out_last=1 when m=K-1; after the last beat, pulse done and go to IDLE.
REQ-029 din_ready=0 outside LOAD states; cmd_valid outside IDLE SHALL be ignored with no side effect.
REQ-030 Counter SHALL be 2*LOG_K bits wide; no wrap-around occurs because each terminal count forces a state exit.
Reset
REQ-031 Reset SHALL force IDLE, clear counters and both loaded flags, and drive every output to 0 except cmd_ready=1; datapath memory contents are untouched.
REQ-032 Reset mid-operation SHALL abort with no done or err pulse; the next RUN requires fresh LOAD_A and LOAD_X.
Structure
REQ-033 Package mvm_sched_pkg SHALL hold the state enum and the cmd_op constants OP_LOAD_A, OP_LOAD_X, OP_RUN.
REQ-034 Single module with no sub-module; outputs decoded combinationally from state, counter and handshakes.
Verification
REQ-035 A[r][c]=r+1, X all 1, RUN, out_ready=1 -> beats 8,16,...,64 on sel_y 0..7; out_last on beat 7; done one cycle after.
REQ-036 RUN immediately after reset -> err pulse, no clear_acc, no wr_en_y, cmd_ready back high.
REQ-037 Random din_valid gaps during LOAD_A -> exactly 64 wr_en_a pulses, 8 per bit, addr_a 0..7 per row; same results as REQ-035.
REQ-038 out_ready toggled 1010 during OUT -> sel_y holds while stalled, 8 beats total, no duplicated or dropped lane.
REQ-039 Reset asserted in MAC cycle 4 -> all outputs 0 next cycle, then RUN gives err until both loads repeat.
REQ-040 cmd_valid held high during MAC, then LOAD_X with X=2 and RUN -> command ignored while busy, then outputs 16..128 with A reused.
